fc_seq_ctrl: RTL
================

Name: fc_seq_ctrl

Overview:
- Sequencer for one fully-connected layer pass over the src_buf → MAC → dst_buf datapath.
- For each output neuron o, streams input reads ia = 0..in_n-1 (with matching weight address) into the MAC, marks first/last terms, and issues the dst_buf write strobe (outr/oa) once the accumulated result emerges from the MAC pipeline.
- Sits between the host-side layer control (run/done) and the buffers/MAC.

Parameters:
- AW, 12, src/dst buffer address width (ia, oa, in_n, out_n).
- WW, 24, weight address width (wa); wraps modulo 2^WW.
- MAC_LAT, 2, cycles from the src_buf read data d being valid to the MAC result x being valid; legal range 1..8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- run  input  1  start pulse; sampled only in IDLE
- in_n  input  AW  inputs per neuron; latched at run
- out_n  input  AW  neurons in layer; latched at run
- exec  output  1  src_buf read enable
- ia  output  AW  src_buf read address
- wa  output  WW  weight memory read address, valid with exec
- acc_init  output  1  aligned with d (exec+1): first term, MAC clears its accumulator
- acc_last  output  1  aligned with d (exec+1): last term of the neuron
- outr  output  1  dst_buf write request
- oa  output  AW  dst_buf write address, valid with outr
- busy  output  1  high from the cycle after an accepted run until the done pulse
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: every output is 0. State → IDLE. Counters and the delay pipeline are cleared. Reset mid-run discards all in-flight work; no outr is issued afterwards.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE + run: latch in_n/out_n; i=0, o=0, wa=0; go to ISSUE, or to FIN if in_n==0 or out_n==0.
  - ISSUE: exec=1 every cycle with ia=i and wa as counted.
    - After each exec: i++ and wa++.
    - When i==in_n-1: i←0, o++.
    - On the exec of the last term of neuron out_n-1, go to DRAIN.
  - DRAIN: exec=0. Wait until the delay pipeline is empty, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Issue is back-to-back: a layer takes in_n*out_n exec cycles with no bubbles between neurons.
- acc_init and acc_last are exec-time flags (i==0, i==in_n-1), registered one cycle so they align with src_buf's 1-cycle read latency. With in_n==1, both are high on the same term.
- Write-back pipeline:
  - The last-term exec for neuron o pushes {valid, o} into a shift register of depth MAC_LAT+1.
  - outr=1, oa=o exactly MAC_LAT+1 cycles after that exec, i.e. the cycle x is valid.
  - outr is a single-cycle pulse per neuron. Consecutive neurons may produce outr on consecutive cycles (in_n==1).
- Counter widths: i and o are AW bits. Done is detected by comparison with the latched value minus 1, never by overflow, so in_n=4095 and out_n=4095 are legal.
- wa is the linear index o*in_n+i, maintained incrementally with no multiplier.
- run while busy is ignored. run in the same cycle as FIN is ignored; it is accepted in IDLE only.
- Config inputs are don't-care after run is accepted.

Optional Feature:
- Macro FC_SEQ_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - In ISSUE, stall=1 forces exec=0 and freezes i, o and wa.
  - The delay pipeline keeps shifting, so already-issued last terms still produce outr on schedule.
  - acc_init/acc_last follow exec, so they are 0 in the cycle after a stalled cycle.
  - stall has no effect in IDLE, DRAIN or FIN.
- Undefined: no stall port; issue is never interrupted.

Test Plan:
- MAC_LAT=2, in_n=3, out_n=2, run at cycle 0:
  - exec high cycles 1–6, ia=0,1,2,0,1,2, wa=0..5.
  - acc_init at cycles 2 and 5; acc_last at cycles 4 and 7.
  - outr at cycles 6 (oa=0) and 9 (oa=1).
  - done at cycle 10; busy high cycles 1–9.
- in_n=1, out_n=4: exec cycles 1–4. acc_init and acc_last are both high on every term. outr on 4 consecutive cycles with oa=0,1,2,3.
- in_n=0, out_n=5: no exec, no outr; done pulses at cycle 1. Repeat with in_n=5, out_n=0: same result.
- reset asserted during the 2nd neuron of in_n=4, out_n=3: outputs 0 the next cycle. No later outr or done. A new run then completes normally.
- run pulsed again mid-layer and on the FIN cycle: ignored. exec count = in_n*out_n, and there is exactly one done.
- FC_SEQ_STALL_EN, in_n=2, out_n=2, stall high cycles 2–3: ia sequence 0, (hold), (hold), 1, 0, 1. Total of 4 exec. outr oa=0 occurs 3 cycles after the exec of ia=1 at cycle 4.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: streams src_buf/weight reads into the MAC and schedules dst_buf write-back.
// Optional macro FC_SEQ_STALL_EN adds a stall input that pauses issue without disturbing write-back timing.
module fc_seq_ctrl #(
    parameter int AW      = 12,
    parameter int WW      = 24,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
`ifdef FC_SEQ_STALL_EN
    input  logic          stall,
`endif
    input  logic [AW-1:0] in_n,
    input  logic [AW-1:0] out_n,
    output logic          exec,
    output logic [AW-1:0] ia,
    output logic [WW-1:0] wa,
    output logic          acc_init,
    output logic          acc_last,
    output logic          outr,
    output logic [AW-1:0] oa,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [WW-1:0] ONE_W = WW'(1);

    state_t state, nxt;

    logic [AW-1:0] i_cnt, o_cnt;
    logic [AW-1:0] in_m1, out_m1;
    logic [WW-1:0] wa_cnt;
    logic          hold;
    logic          term_last;
    logic          layer_last;

    // Write-back delay line: one entry per neuron, tapped at MAC_LAT so outr lines up with x.
    logic [MAC_LAT:0]         vld_pipe;
    logic [MAC_LAT:0][AW-1:0] oa_pipe;

`ifdef FC_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign term_last  = exec && (i_cnt == in_m1);
    assign layer_last = term_last && (o_cnt == out_m1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt  = state;
        exec = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (run) nxt = (in_n == '0 || out_n == '0) ? FIN : ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                exec = !hold;
                if (layer_last) nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave once only the entry now presenting outr remains in flight.
                if (vld_pipe[MAC_LAT-1:0] == '0) nxt = FIN;
            end
            FIN: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_cnt    <= '0;
            o_cnt    <= '0;
            wa_cnt   <= '0;
            in_m1    <= '0;
            out_m1   <= '0;
            acc_init <= 1'b0;
            acc_last <= 1'b0;
            vld_pipe <= '0;
            oa_pipe  <= '0;
        end else begin
            if (state == IDLE && run) begin
                i_cnt  <= '0;
                o_cnt  <= '0;
                wa_cnt <= '0;
                in_m1  <= in_n - ONE_A;
                out_m1 <= out_n - ONE_A;
            end else if (exec) begin
                // wa tracks o*in_n+i incrementally; it never resets between neurons.
                wa_cnt <= wa_cnt + ONE_W;
                if (term_last) begin
                    i_cnt <= '0;
                    o_cnt <= o_cnt + ONE_A;
                end else begin
                    i_cnt <= i_cnt + ONE_A;
                end
            end
            acc_init <= exec && (i_cnt == '0);
            acc_last <= term_last;
            vld_pipe <= {vld_pipe[MAC_LAT-1:0], term_last};
            oa_pipe  <= {oa_pipe[MAC_LAT-1:0], o_cnt};
        end
    end

    assign ia   = i_cnt;
    assign wa   = wa_cnt;
    assign outr = vld_pipe[MAC_LAT];
    assign oa   = oa_pipe[MAC_LAT];

endmodule
